// File: rtl/wb_arbiter.sv
// wb_arbiter: shares one register-file write port between the load path and
// the ALU path. Loads always win; ALU results that lose the port wait in a
// small in-order holding buffer and drain when the port is free.
module wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    input  logic [ADDR_W-1:0]          alu_rd,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       mem_valid,
    input  logic [ADDR_W-1:0]          mem_rd,
    input  logic [DATA_W-1:0]          mem_data,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    output logic                       alu_stall,
    output logic [$clog2(DEPTH):0]     buf_count,
    output logic                       ovf_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    wb_entry_t [DEPTH-1:0] buf_q, buf_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     waddr_q, waddr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;

    logic      buf_empty, buf_full;
    logic      sel_buf, sel_alu;
    logic      enq, deq, drop;
    wb_entry_t head;

    // Arbitration: load first, then buffer head, then ALU bypass (empty buffer only)
    always_comb begin
        buf_empty = (count_q == '0);
        buf_full  = (count_q == DEPTH_C);
        head      = buf_q[rd_ptr_q];
        sel_buf   = !mem_valid && !buf_empty;
        sel_alu   = !mem_valid && buf_empty && alu_valid;
        deq       = sel_buf;
        // A full buffer still accepts when the head drains on the same edge.
        enq       = alu_valid && !sel_alu && (!buf_full || deq);
        drop      = alu_valid && !sel_alu && !enq;
    end

    // Next-state for write port, buffer storage, pointers, occupancy, overflow
    always_comb begin
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        buf_d    = buf_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | drop;

        if (mem_valid) begin
            we_d    = 1'b1;
            waddr_d = mem_rd;
            wdata_d = mem_data;
        end else if (sel_buf) begin
            we_d    = 1'b1;
            waddr_d = head.rd;
            wdata_d = head.data;
        end else if (sel_alu) begin
            we_d    = 1'b1;
            waddr_d = alu_rd;
            wdata_d = alu_data;
        end

        if (enq) begin
            buf_d[wr_ptr_q].rd   = alu_rd;
            buf_d[wr_ptr_q].data = alu_data;
        end

        // Power-of-two depth lets the pointers wrap by natural overflow.
        rd_ptr_d = rd_ptr_q + PW'(deq);
        wr_ptr_d = wr_ptr_q + PW'(enq);
        count_d  = count_q + CW'(enq) - CW'(deq);
    end

    // State registers; reset clears everything, discarding buffered entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            buf_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            buf_q    <= buf_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign rf_we     = we_q;
    assign rf_waddr  = waddr_q;
    assign rf_wdata  = wdata_q;
    assign buf_count = count_q;
    assign alu_stall = (count_q == DEPTH_C);
    assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (DATA_W=16, ADDR_W=3, DEPTH=2).
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [2:0]  alu_rd;
    logic [15:0] alu_data;
    logic        mem_valid;
    logic [2:0]  mem_rd;
    logic [15:0] mem_data;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        alu_stall;
    logic [1:0]  buf_count;
    logic        ovf_err;

    int n_assert = 0;
    int n_fail   = 0;

    wb_arbiter #(.DATA_W(16), .ADDR_W(3), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_stall(alu_stall), .buf_count(buf_count), .ovf_err(ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full output snapshot check
    task automatic chk_all(input string tag, input logic we, input logic [2:0] wa,
                           input logic [15:0] wd, input logic [1:0] cnt,
                           input logic stall, input logic ovf);
        chk({tag, ".we"},    32'(rf_we),     32'(we));
        chk({tag, ".waddr"}, 32'(rf_waddr),  32'(wa));
        chk({tag, ".wdata"}, 32'(rf_wdata),  32'(wd));
        chk({tag, ".count"}, 32'(buf_count), 32'(cnt));
        chk({tag, ".stall"}, 32'(alu_stall), 32'(stall));
        chk({tag, ".ovf"},   32'(ovf_err),   32'(ovf));
    endtask

    task automatic drive(input logic av, input logic [2:0] ard, input logic [15:0] ad,
                         input logic mv, input logic [2:0] mrd, input logic [15:0] md);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
    endtask

    // Idle with garbage on the payloads: must be ignored when valid is low
    task automatic idle();
        drive(1'b0, 3'($urandom), 16'($urandom), 1'b0, 3'($urandom), 16'($urandom));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk_all("reset", 0, 0, 16'h0000, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ALU only: bypass, 1-cycle latency
        drive(1, 3, 16'h1234, 0, 0, 0);
        tick();
        chk_all("alu_only", 1, 3, 16'h1234, 0, 0, 0);
        idle();
        tick();
        chk_all("idle_hold", 0, 3, 16'h1234, 0, 0, 0);

        // Collision: load first, ALU one cycle later
        drive(1, 2, 16'h5555, 1, 1, 16'hAAAA);
        tick();
        chk_all("coll_mem", 1, 1, 16'hAAAA, 1, 0, 0);
        idle();
        tick();
        chk_all("coll_alu", 1, 2, 16'h5555, 0, 0, 0);
        idle();
        tick();
        chk("coll_idle.we", 32'(rf_we), 0);

        // Fill / stall / overflow
        drive(1, 0, 16'hB000, 1, 6, 16'h0A00);
        tick();
        chk_all("fill1", 1, 6, 16'h0A00, 1, 0, 0);
        drive(1, 1, 16'hB001, 1, 6, 16'h0A01);
        tick();
        chk_all("fill2", 1, 6, 16'h0A01, 2, 1, 0);
        drive(1, 2, 16'hB002, 1, 6, 16'h0A02);
        tick();
        chk_all("fill3_drop", 1, 6, 16'h0A02, 2, 1, 1);
        idle();
        tick();
        chk_all("drain1", 1, 0, 16'hB000, 1, 0, 1);
        idle();
        tick();
        chk_all("drain2", 1, 1, 16'hB001, 0, 0, 1);
        idle();
        tick();
        chk_all("drain_done", 0, 1, 16'hB001, 0, 0, 1);

        // Reset clears the sticky overflow
        rst_n = 1'b0;
        #1;
        chk_all("rst_ovf", 0, 0, 16'h0000, 0, 0, 0);
        rst_n = 1'b1;

        // Ordering and pointer wrap across 5 bursts
        for (int i = 0; i < 5; i++) begin
            drive(1, 3'(i), 16'hD000 + 16'(i), 1, 7, 16'hC000 + 16'(i));
            tick();
            chk_all($sformatf("wrap_mem%0d", i), 1, 7, 16'hC000 + 16'(i), 1, 0, 0);
            idle();
            tick();
            chk_all($sformatf("wrap_alu%0d", i), 1, 3'(i), 16'hD000 + 16'(i), 0, 0, 0);
        end

        // Same destination: load 00FF before buffered 0001
        drive(1, 5, 16'h0001, 1, 6, 16'h1111);
        tick();
        chk_all("samerd_a", 1, 6, 16'h1111, 1, 0, 0);
        drive(0, 0, 0, 1, 5, 16'h00FF);
        tick();
        chk_all("samerd_mem", 1, 5, 16'h00FF, 1, 0, 0);
        idle();
        tick();
        chk_all("samerd_alu", 1, 5, 16'h0001, 0, 0, 0);

        // Full buffer, no load: head drains and new entry enqueues same edge
        drive(1, 1, 16'hE001, 1, 7, 16'h0000);
        tick();
        drive(1, 2, 16'hE002, 1, 7, 16'h0000);
        tick();
        chk_all("full2", 1, 7, 16'h0000, 2, 1, 0);
        drive(1, 3, 16'hE003, 0, 0, 0);
        tick();
        chk_all("full_deq_enq", 1, 1, 16'hE001, 2, 1, 0);

        // Async reset mid-cycle with 2 buffered entries
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 16'h0000, 0, 0, 0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("post_rst%0d", i), 0, 0, 16'h0000, 0, 0, 0);
        end
        drive(1, 4, 16'h4444, 0, 0, 0);
        tick();
        chk_all("post_rst_bypass", 1, 4, 16'h4444, 0, 0, 0);
        idle();
        tick();
        chk_all("post_rst_end", 0, 4, 16'h4444, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
